l2_cache: RTL and testbench

- Direct-mapped, write-back second-level cache. It is the responder on the shared L2 request interface driven by the I/D cache arbiter.
- Serves full-line (lc3b_line, 128-bit) reads and writes addressed by lc3b_word byte addresses.
- On a miss it acts as the initiator toward physical memory: write-back of a dirty victim, then line fill.
- Sits between the arbiter and pmem.

---
 rtl/l2_cache.sv | 114 +++++++++++
 tb/tb_l2_cache.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_cache.sv
// Direct-mapped write-back L2 cache: zero-wait full-line hits, and on a miss
// a dirty-victim write-back to pmem followed by a line fill.
module l2_cache #(
    parameter int unsigned NUM_SETS = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [15:0]  L2_address,
    input  logic         L2_read,
    input  logic         L2_write,
    input  logic [127:0] L2_wdata,
    output logic [127:0] L2_rdata,
    output logic         L2_resp,
    output logic [15:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam int unsigned INDEX_W = $clog2(NUM_SETS);
    localparam int unsigned TAG_W   = 12 - INDEX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_e;

    state_e               state_q;
    logic [NUM_SETS-1:0]  valid_q;
    logic [NUM_SETS-1:0]  dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_SETS];
    logic [127:0]         data_q [NUM_SETS];
    logic [INDEX_W-1:0]   miss_index_q;
    logic [TAG_W-1:0]     miss_tag_q;

    logic [INDEX_W-1:0]   index;
    logic [TAG_W-1:0]     tag;
    logic                 req;
    logic                 hit;
    logic                 wr_hit;
    logic                 unused_offset;

    assign index         = L2_address[4 +: INDEX_W];
    assign tag           = L2_address[15 -: TAG_W];
    assign unused_offset = ^L2_address[3:0];
    assign req           = L2_read | L2_write;
    assign hit           = valid_q[index] && (tag_q[index] == tag);

    assign L2_resp    = (state_q == IDLE) && req && hit;
    assign L2_rdata   = data_q[index];
    assign wr_hit     = L2_resp && L2_write;

    // Miss index/tag are latched so the pmem transaction stays stable even if
    // the requester misbehaves and drops or changes its request mid-miss.
    assign pmem_write = (state_q == WRITEBACK);
    assign pmem_read  = (state_q == FILL);
    assign pmem_wdata = data_q[miss_index_q];

    always_comb begin
        pmem_address = '0;
        unique case (state_q)
            WRITEBACK: pmem_address = {tag_q[miss_index_q], miss_index_q, 4'b0000};
            FILL:      pmem_address = {miss_tag_q, miss_index_q, 4'b0000};
            default:   pmem_address = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req && !hit) begin
                        miss_index_q <= index;
                        miss_tag_q   <= tag;
                        state_q      <= dirty_q[index] ? WRITEBACK : FILL;
                    end else if (wr_hit) begin
                        dirty_q[index] <= 1'b1;
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        dirty_q[miss_index_q] <= 1'b0;
                        state_q               <= FILL;
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        valid_q[miss_index_q] <= 1'b1;
                        dirty_q[miss_index_q] <= 1'b0;
                        state_q               <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag and data storage is never cleared by reset; valid bits gate its use.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (wr_hit) begin
                data_q[index] <= L2_wdata;
            end
            if (state_q == FILL && pmem_resp) begin
                data_q[miss_index_q] <= pmem_rdata;
                tag_q[miss_index_q]  <= miss_tag_q;
            end
        end
    end

endmodule

// File: tb/tb_l2_cache.sv
// Bench for l2_cache: transaction-level cache model plus a pmem responder with
// random latency; directed scenarios pin the model, then random traffic.
module tb_l2_cache;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [15:0]  L2_address = '0;
    logic         L2_read = 1'b0;
    logic         L2_write = 1'b0;
    logic [127:0] L2_wdata = '0;
    logic [127:0] L2_rdata;
    logic         L2_resp;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;

    l2_cache #(.NUM_SETS(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .L2_address   (L2_address),
        .L2_read      (L2_read),
        .L2_write     (L2_write),
        .L2_wdata     (L2_wdata),
        .L2_rdata     (L2_rdata),
        .L2_resp      (L2_resp),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Physical memory: lines created with random content on first touch.
    logic [127:0] mem [bit [15:0]];

    function automatic logic [127:0] get_line(input bit [15:0] a);
        if (!mem.exists(a)) mem[a] = {$urandom(), $urandom(), $urandom(), $urandom()};
        return mem[a];
    endfunction

    typedef struct {
        bit           wr;
        logic [15:0]  addr;
        logic [127:0] data;
    } op_t;

    op_t log_q[$];
    op_t exp_q[$];

    // pmem responder and per-cycle protocol checks
    int  lat_fixed = -1;
    bit  busy = 1'b0;
    int  cnt = 0;
    int  pulse_cyc = -10;
    op_t cur;

    always @(negedge clk) begin
        check("pmem_excl", pmem_read && pmem_write, 1'b0);
        if (pmem_resp) begin
            pmem_resp = 1'b0;
        end else if (!busy) begin
            if (pmem_read || pmem_write) begin
                busy     = 1'b1;
                cur.wr   = pmem_write;
                cur.addr = pmem_address;
                cur.data = pmem_write ? pmem_wdata : '0;
                log_q.push_back(cur);
                cnt = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 4));
                check("pmem_align", pmem_address[3:0], 4'h0);
            end
        end else if (!(pmem_read || pmem_write)) begin
            busy = 1'b0;
        end else begin
            check("pmem_hold_kind", pmem_write, cur.wr);
            check("pmem_hold_addr", pmem_address, cur.addr);
            if (cur.wr) check("pmem_hold_data", pmem_wdata, cur.data);
        end
        if (busy) begin
            if (cnt == 0) begin
                pmem_resp = 1'b1;
                if (cur.wr) mem[cur.addr] = cur.data;
                else pmem_rdata = get_line(cur.addr);
                pulse_cyc = cyc;
                busy = 1'b0;
            end else begin
                cnt--;
            end
        end
    end

    always @(posedge clk) begin
        #3;
        if (!(L2_read || L2_write)) check("resp_no_req", L2_resp, 1'b0);
    end

    // Behavioural cache model
    bit           mv [8];
    bit           md [8];
    logic [8:0]   mt [8];
    logic [127:0] mdat [8];

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
        end
    endtask

    // Called at a negedge; returns at the negedge after the request is dropped.
    task automatic do_req(input bit rd, input bit wr, input logic [15:0] a,
                          input logic [127:0] wd, output logic [127:0] got);
        int           idx;
        logic [8:0]   tg;
        logic [15:0]  la;
        logic [127:0] fill;
        logic [127:0] exp_rd;
        bit           hit;
        int           n;
        op_t          o;
        idx  = int'(a[6:4]);
        tg   = a[15:7];
        la   = {a[15:4], 4'h0};
        hit  = mv[idx] && (mt[idx] == tg);
        fill = '0;
        exp_q.delete();
        log_q.delete();
        if (!hit) begin
            if (md[idx]) begin
                o.wr = 1'b1; o.addr = {mt[idx], idx[2:0], 4'h0}; o.data = mdat[idx];
                exp_q.push_back(o);
            end
            fill = get_line(la);
            o.wr = 1'b0; o.addr = la; o.data = '0;
            exp_q.push_back(o);
        end
        exp_rd = hit ? mdat[idx] : fill;

        L2_address = a;
        L2_read    = rd;
        L2_write   = wr;
        L2_wdata   = wd;
        #1;
        n = 0;
        while (!L2_resp && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("l2_resp_seen", L2_resp, 1'b1);
        if (hit) check("hit_latency", n, 0);
        else check("miss_latency", cyc, pulse_cyc + 1);
        if (!wr) check("l2_rdata", L2_rdata, exp_rd);
        got = L2_rdata;
        check("pmem_op_count", log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            check("pmem_op_kind", log_q[i].wr, exp_q[i].wr);
            check("pmem_op_addr", log_q[i].addr, exp_q[i].addr);
            check("pmem_op_data", log_q[i].data, exp_q[i].data);
        end

        if (!hit) begin
            mv[idx] = 1'b1; md[idx] = 1'b0; mt[idx] = tg; mdat[idx] = fill;
        end
        if (wr) begin
            mdat[idx] = wd; md[idx] = 1'b1;
        end

        @(negedge clk);
        L2_read  = 1'b0;
        L2_write = 1'b0;
    endtask

    localparam logic [127:0] LA = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
    localparam logic [127:0] LB = 128'hBBBB_1111_BBBB_2222_BBBB_3333_BBBB_4444;
    localparam logic [127:0] LC = 128'hCCCC_5555_CCCC_6666_CCCC_7777_CCCC_8888;
    localparam logic [127:0] LD = 128'hDDDD_9999_DDDD_AAAA_DDDD_BBBB_DDDD_CCCC;

    initial begin
        logic [127:0] got;
        int           n;
        bit           r;
        bit           w;
        int           k;

        model_reset();
        repeat (3) @(negedge clk);
        check("rst_l2_resp", L2_resp, 1'b0);
        check("rst_pmem_read", pmem_read, 1'b0);
        check("rst_pmem_write", pmem_write, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Cold read, fixed 3-cycle memory latency, then repeat hit
        lat_fixed = 3;
        mem[16'h0040] = LA;
        do_req(1'b1, 1'b0, 16'h0040, '0, got);
        check("cold_rdata", got, LA);
        check("cold_ops", log_q.size(), 1);
        check("cold_addr", log_q[0].addr, 16'h0040);
        check("cold_kind", log_q[0].wr, 1'b0);
        do_req(1'b1, 1'b0, 16'h0040, '0, got);
        check("rehit_rdata", got, LA);
        check("rehit_ops", log_q.size(), 0);

        // Write hit, then read with a different offset
        do_req(1'b0, 1'b1, 16'h0040, LB, got);
        check("wrhit_ops", log_q.size(), 0);
        do_req(1'b1, 1'b0, 16'h0048, '0, got);
        check("offset_rdata", got, LB);

        // Dirty conflict: write-back B to 0x0040, then fill 0x00C0
        mem[16'h00C0] = LC;
        do_req(1'b1, 1'b0, 16'h00C0, '0, got);
        check("conf_rdata", got, LC);
        check("conf_ops", log_q.size(), 2);
        check("conf_wb_kind", log_q[0].wr, 1'b1);
        check("conf_wb_addr", log_q[0].addr, 16'h0040);
        check("conf_wb_data", log_q[0].data, LB);
        check("conf_fill_addr", log_q[1].addr, 16'h00C0);
        check("conf_mem", mem[16'h0040], LB);

        // Clean conflict: fill only, and memory now holds B
        do_req(1'b1, 1'b0, 16'h0040, '0, got);
        check("clean_rdata", got, LB);
        check("clean_ops", log_q.size(), 1);
        check("clean_kind", log_q[0].wr, 1'b0);

        // Reset in the middle of a fill
        lat_fixed = 8;
        L2_address = 16'h0140;
        L2_read    = 1'b1;
        n = 0;
        while (!pmem_read && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("midfill_started", pmem_read, 1'b1);
        reset   = 1'b1;
        L2_read = 1'b0;
        @(negedge clk);
        #1;
        check("midfill_rd_low", pmem_read, 1'b0);
        check("midfill_wr_low", pmem_write, 1'b0);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        lat_fixed = 2;
        do_req(1'b1, 1'b0, 16'h0140, '0, got);
        check("refetch_ops", log_q.size(), 1);
        check("refetch_addr", log_q[0].addr, 16'h0140);
        do_req(1'b1, 1'b0, 16'h0040, '0, got);
        check("after_rst_miss", log_q.size(), 1);

        // Read and write together on a hit: write wins
        do_req(1'b1, 1'b0, 16'h0010, '0, got);
        do_req(1'b1, 1'b1, 16'h0010, LD, got);
        check("both_ops", log_q.size(), 0);
        do_req(1'b1, 1'b0, 16'h001C, '0, got);
        check("both_rdata", got, LD);

        // Random traffic over a few tags per set to force conflicts
        lat_fixed = -1;
        for (int i = 0; i < 400; i++) begin
            k = int'($urandom_range(0, 3));
            w = (k <= 1);
            r = (k >= 1);
            do_req(r, w, {7'd0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))},
                   {$urandom(), $urandom(), $urandom(), $urandom()}, got);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
